// File: rtl/reg_file_wb.sv
// 32-entry register file: two combinational read ports, one debug read port,
// one synchronous write port, and a counter of effective writes.
// Build option: define REGFILE_BYPASS_EN for write-through forwarding on all read ports.
module reg_file_wb #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [WIDTH-1:0]  dbg_rd,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0] wr_count_q;
    logic [CNT_W-1:0] wr_count_d;
    logic             eff_we;
    logic             fwd1;
    logic             fwd2;
    logic             fwd_dbg;

    // Writes to r0 are dropped entirely, including the counter update.
    assign eff_we     = we && (wa != '0);
    assign wr_count_d = eff_we ? wr_count_q + CNT_W'(1) : wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (eff_we) begin
                regs_q[wa] <= wd;
            end
            wr_count_q <= wr_count_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1    = eff_we && (ra1 == wa);
    assign fwd2    = eff_we && (ra2 == wa);
    assign fwd_dbg = eff_we && (dbg_ra == wa);
`else
    assign fwd1    = 1'b0;
    assign fwd2    = 1'b0;
    assign fwd_dbg = 1'b0;
`endif

    // Address 0 always reads zero; forwarding can never hit it since eff_we excludes wa==0.
    assign rd1    = (ra1 == '0)    ? '0 : (fwd1    ? wd : regs_q[ra1]);
    assign rd2    = (ra2 == '0)    ? '0 : (fwd2    ? wd : regs_q[ra2]);
    assign dbg_rd = (dbg_ra == '0) ? '0 : (fwd_dbg ? wd : regs_q[dbg_ra]);

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb; a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_reg_file_wb;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] dbg_ra;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  dbg_rd;
    logic [31:0]       wr_count;
    logic [WIDTH-1:0]  w_rd1;
    logic [WIDTH-1:0]  w_rd2;
    logic [WIDTH-1:0]  w_dbg_rd;
    logic [3:0]        w_wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_wb u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .dbg_ra   (dbg_ra),
        .dbg_rd   (dbg_rd),
        .wr_count (wr_count)
    );

    reg_file_wb #(.CNT_W(4)) u_dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (w_rd1),
        .rd2      (w_rd2),
        .dbg_ra   (dbg_ra),
        .dbg_rd   (w_dbg_rd),
        .wr_count (w_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we    = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 32; i++) begin
            ra1    = ADDR_W'(i);
            ra2    = ADDR_W'(31 - i);
            dbg_ra = ADDR_W'(i);
            #1;
            n_checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0 || dbg_rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d rd1=%h rd2=%h dbg=%h required 0", i, rd1, rd2, dbg_rd);
            end
        end
        n_checks++;
        if (wr_count !== 32'h0 || w_wr_count !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_count got %h/%h required 0/0", wr_count, w_wr_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_readback();
        write_reg(5'd5, 32'hDEADBEEF);
        ra1 = 5'd5; ra2 = 5'd5; dbg_ra = 5'd5;
        #1;
        n_checks++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF || dbg_rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_readback rd1=%h rd2=%h dbg=%h required deadbeef", rd1, rd2, dbg_rd);
        end
        n_checks++;
        if (wr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL write_count got %0d required 1", wr_count);
        end
    endtask

    task automatic test_r0_protect();
        write_reg(5'd0, 32'hFFFFFFFF);
        ra1 = 5'd0; ra2 = 5'd0; dbg_ra = 5'd0;
        #1;
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || dbg_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_read rd1=%h rd2=%h dbg=%h required 0", rd1, rd2, dbg_rd);
        end
        n_checks++;
        if (wr_count !== 32'd1) begin
            n_fail++;
            $display("FAIL r0_count got %0d required 1", wr_count);
        end
        // r0 must also read 0 while a write to r0 is being presented
        we = 1'b1; wa = 5'd0; wd = 32'h12345678;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_pending_write rd1=%h required 0", rd1);
        end
        we = 1'b0;
    endtask

    task automatic test_read_during_write();
        logic [WIDTH-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h22222222;
`else
        exp_pre = 32'h11111111;
`endif
        write_reg(5'd7, 32'h11111111);
        we = 1'b1; wa = 5'd7; wd = 32'h22222222;
        ra1 = 5'd7; ra2 = 5'd5; dbg_ra = 5'd7;
        #1;
        n_checks++;
        if (rd1 !== exp_pre || dbg_rd !== exp_pre) begin
            n_fail++;
            $display("FAIL rdw_before_edge rd1=%h dbg=%h required %h", rd1, dbg_rd, exp_pre);
        end
        n_checks++;
        if (rd2 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rdw_other_port rd2=%h required deadbeef", rd2);
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h22222222 || dbg_rd !== 32'h22222222) begin
            n_fail++;
            $display("FAIL rdw_after_edge rd1=%h dbg=%h required 22222222", rd1, dbg_rd);
        end
        n_checks++;
        if (wr_count !== 32'd3) begin
            n_fail++;
            $display("FAIL rdw_count got %0d required 3", wr_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1;
            wa = ADDR_W'(i);
            wd = 32'hC3000000 | 32'(i * 257);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [WIDTH-1:0] exp;
            exp    = (i == 0) ? 32'h0 : (32'hC3000000 | 32'(i * 257));
            ra1    = ADDR_W'(i);
            ra2    = ADDR_W'(i);
            dbg_ra = ADDR_W'(i);
            #1;
            n_checks++;
            if (rd1 !== exp || rd2 !== exp || dbg_rd !== exp) begin
                n_fail++;
                $display("FAIL b2b_read addr=%0d rd1=%h rd2=%h dbg=%h required %h", i, rd1, rd2, dbg_rd, exp);
            end
        end
        n_checks++;
        if (wr_count !== 32'd34) begin
            n_fail++;
            $display("FAIL b2b_count got %0d required 34", wr_count);
        end
    endtask

    task automatic test_async_reset();
        write_reg(5'd9, 32'hA5A5A5A5);
        ra1 = 5'd9; ra2 = 5'd9; dbg_ra = 5'd9;
        #1;
        n_checks++;
        if (rd1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL async_pre rd1=%h required a5a5a5a5", rd1);
        end
        we = 1'b1; wa = 5'd9; wd = 32'h5A5A5A5A;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || dbg_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL async_clear rd1=%h rd2=%h dbg=%h required 0", rd1, rd2, dbg_rd);
        end
        n_checks++;
        if (wr_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_count got %0d required 0", wr_count);
        end
        tick();
        n_checks++;
        if (rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_beats_write rd1=%h required 0", rd1);
        end
        we = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rd1 !== 32'h0 || wr_count !== 32'h0) begin
            n_fail++;
            $display("FAIL post_release rd1=%h cnt=%0d required 0/0", rd1, wr_count);
        end
    endtask

    task automatic test_counter_wrap();
        for (int k = 1; k <= 17; k++) begin
            write_reg(ADDR_W'((k % 31) + 1), 32'(k));
            if (k == 15) begin
                n_checks++;
                if (w_wr_count !== 4'hF) begin
                    n_fail++;
                    $display("FAIL wrap_15 got %h required f", w_wr_count);
                end
            end
            if (k == 16) begin
                n_checks++;
                if (w_wr_count !== 4'h0) begin
                    n_fail++;
                    $display("FAIL wrap_16 got %h required 0", w_wr_count);
                end
            end
        end
        n_checks++;
        if (w_wr_count !== 4'h1) begin
            n_fail++;
            $display("FAIL wrap_17 got %h required 1", w_wr_count);
        end
        n_checks++;
        if (wr_count !== 32'd17) begin
            n_fail++;
            $display("FAIL wide_count got %0d required 17", wr_count);
        end
        // first write after release landed on the first edge: k=1 went to r2
        ra1 = 5'd2;
        #1;
        n_checks++;
        if (rd1 !== 32'd1) begin
            n_fail++;
            $display("FAIL first_write_after_release rd1=%h required 1", rd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0; dbg_ra = '0;
        test_reset();
        test_write_readback();
        test_r0_protect();
        test_read_during_write();
        test_back_to_back();
        test_async_reset();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
